// File: rtl/thread_fetch_sched.sv
// thread_fetch_sched
//   Round-robin fetch scheduler for the 4-thread SMT front end. Holds one PC per
//   hardware thread, grants one eligible thread per cycle to fetch a bundle of
//   FETCH_WIDTH instructions, and tags the fetch with a registered thread ID.
//   Back-end redirects overwrite the PC of the affected thread.
//
// Ports
//   i_Clk              clock, rising edge
//   i_Reset_n          asynchronous active-low reset
//   i_Stall            global front-end stall, freezes scheduling
//   i_Thread_Ready     per-thread fetch permission
//   i_Redirect_Valid   redirect request this cycle
//   i_Redirect_Thread  thread being redirected
//   i_Redirect_PC      new PC for the redirected thread
//   o_Fetch_Valid      fetch issued this cycle
//   o_Fetch_PC         fetch address of the granted thread
//   o_thread           granted thread ID, zero-extended
//   o_Thread_PC        all PC registers, thread 3 in the MSBs
module thread_fetch_sched #(
    parameter int unsigned                  ADDRESS_WIDTH    = 32,
    parameter int unsigned                  FETCH_WIDTH      = 4,
    parameter logic [ADDRESS_WIDTH-1:0]     RESET_PC_BASE    = '0,
    parameter logic [ADDRESS_WIDTH-1:0]     THREAD_PC_STRIDE = ADDRESS_WIDTH'(32'h0000_1000)
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset_n,
    input  logic                        i_Stall,
    input  logic [3:0]                  i_Thread_Ready,
    input  logic                        i_Redirect_Valid,
    input  logic [1:0]                  i_Redirect_Thread,
    input  logic [ADDRESS_WIDTH-1:0]    i_Redirect_PC,
    output logic                        o_Fetch_Valid,
    output logic [ADDRESS_WIDTH-1:0]    o_Fetch_PC,
    output logic [ADDRESS_WIDTH-1:0]    o_thread,
    output logic [4*ADDRESS_WIDTH-1:0]  o_Thread_PC
);

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4 * FETCH_WIDTH);

    logic [ADDRESS_WIDTH-1:0] pc_q [4];
    logic [ADDRESS_WIDTH-1:0] pc_d [4];
    logic [1:0]               last_q, last_d;
    logic                     valid_q, valid_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]               thread_q, thread_d;

    logic [3:0]               elig;
    logic                     grant_found;
    logic [1:0]               grant_idx;
    logic [1:0]               idx;

    // A thread being redirected this cycle is never granted, so the grant
    // increment and the redirect write can never hit the same PC.
    always_comb begin
        elig = i_Thread_Ready;
        if (i_Redirect_Valid) begin
            elig[i_Redirect_Thread] = 1'b0;
        end

        // Search starts one past the last grant and wraps.
        grant_found = 1'b0;
        grant_idx   = last_q;
        idx         = last_q;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!grant_found && elig[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            pc_d[n] = pc_q[n];
        end
        last_d     = last_q;
        valid_d    = valid_q;
        fetch_pc_d = fetch_pc_q;
        thread_d   = thread_q;

        if (!i_Stall) begin
            if (grant_found) begin
                valid_d         = 1'b1;
                fetch_pc_d      = pc_q[grant_idx];
                thread_d        = grant_idx;
                last_d          = grant_idx;
                pc_d[grant_idx] = pc_q[grant_idx] + PC_STEP;
            end else begin
                valid_d = 1'b0;
            end
        end

        // Redirects apply even while stalled.
        if (i_Redirect_Valid) begin
            pc_d[i_Redirect_Thread] = i_Redirect_PC;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int unsigned n = 0; n < 4; n++) begin
                pc_q[n] <= RESET_PC_BASE + ADDRESS_WIDTH'(n) * THREAD_PC_STRIDE;
            end
            last_q     <= 2'd3;
            valid_q    <= 1'b0;
            fetch_pc_q <= '0;
            thread_q   <= '0;
        end else begin
            for (int unsigned n = 0; n < 4; n++) begin
                pc_q[n] <= pc_d[n];
            end
            last_q     <= last_d;
            valid_q    <= valid_d;
            fetch_pc_q <= fetch_pc_d;
            thread_q   <= thread_d;
        end
    end

    assign o_Fetch_Valid = valid_q;
    assign o_Fetch_PC    = fetch_pc_q;
    assign o_thread      = ADDRESS_WIDTH'(thread_q);
    assign o_Thread_PC   = {pc_q[3], pc_q[2], pc_q[1], pc_q[0]};

endmodule

// File: tb/tb_thread_fetch_sched.sv
module tb_thread_fetch_sched;

    logic         clk;
    logic         rst_n;
    logic         stall;
    logic [3:0]   ready;
    logic         rv;
    logic [1:0]   rt;
    logic [31:0]  rpc;
    logic         f_valid;
    logic [31:0]  f_pc;
    logic [31:0]  f_thread;
    logic [127:0] t_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   ready;
        logic         stall;
        logic         rv;
        logic [1:0]   rt;
        logic [31:0]  rpc;
        logic         ev;
        logic [31:0]  epc;
        logic [31:0]  eth;
        logic [127:0] etpc;
    } vec_t;

    vec_t tbl[$];

    thread_fetch_sched #(
        .ADDRESS_WIDTH   (32),
        .FETCH_WIDTH     (4),
        .RESET_PC_BASE   (32'h0000_0000),
        .THREAD_PC_STRIDE(32'h0000_1000)
    ) dut (
        .i_Clk            (clk),
        .i_Reset_n        (rst_n),
        .i_Stall          (stall),
        .i_Thread_Ready   (ready),
        .i_Redirect_Valid (rv),
        .i_Redirect_Thread(rt),
        .i_Redirect_PC    (rpc),
        .o_Fetch_Valid    (f_valid),
        .o_Fetch_PC       (f_pc),
        .o_thread         (f_thread),
        .o_Thread_PC      (t_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] eth, input logic [127:0] etpc);
        chk({tag, " valid"},  {127'd0, f_valid}, {127'd0, ev});
        chk({tag, " pc"},     {96'd0, f_pc},     {96'd0, epc});
        chk({tag, " thread"}, {96'd0, f_thread}, {96'd0, eth});
        chk({tag, " tpc"},    t_pc,              etpc);
    endtask

    task automatic add(input logic [3:0] rdy, input logic st, input logic v, input logic [1:0] t,
                       input logic [31:0] p, input logic ev, input logic [31:0] epc,
                       input logic [31:0] eth, input logic [127:0] etpc);
        vec_t x;
        x.ready = rdy; x.stall = st; x.rv = v; x.rt = t; x.rpc = p;
        x.ev = ev; x.epc = epc; x.eth = eth; x.etpc = etpc;
        tbl.push_back(x);
    endtask

    task automatic drive(input logic [3:0] rdy, input logic st, input logic v,
                         input logic [1:0] t, input logic [31:0] p);
        ready = rdy; stall = st; rv = v; rt = t; rpc = p;
    endtask

    localparam logic [127:0] RST_TPC = {32'h3000, 32'h2000, 32'h1000, 32'h0};

    initial begin
        // ready stall rv rt rpc | valid pc thread {pc3,pc2,pc1,pc0}
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h0,    32'd0, {32'h3000, 32'h2000, 32'h1000, 32'h10});
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h1000, 32'd1, {32'h3000, 32'h2000, 32'h1010, 32'h10});
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h2000, 32'd2, {32'h3000, 32'h2010, 32'h1010, 32'h10});
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h3000, 32'd3, {32'h3010, 32'h2010, 32'h1010, 32'h10});
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h10,   32'd0, {32'h3010, 32'h2010, 32'h1010, 32'h20});
        add(4'b0101, 0, 0, 2'd0, 32'h0, 1, 32'h2010, 32'd2, {32'h3010, 32'h2020, 32'h1010, 32'h20});
        add(4'b0101, 0, 0, 2'd0, 32'h0, 1, 32'h20,   32'd0, {32'h3010, 32'h2020, 32'h1010, 32'h30});
        add(4'b0101, 0, 0, 2'd0, 32'h0, 1, 32'h2020, 32'd2, {32'h3010, 32'h2030, 32'h1010, 32'h30});
        add(4'b0000, 0, 0, 2'd0, 32'h0, 0, 32'h2020, 32'd2, {32'h3010, 32'h2030, 32'h1010, 32'h30});
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h3010, 32'd3, {32'h3020, 32'h2030, 32'h1010, 32'h30});
        add(4'b1111, 1, 0, 2'd0, 32'h0, 1, 32'h3010, 32'd3, {32'h3020, 32'h2030, 32'h1010, 32'h30});
        add(4'b1111, 1, 0, 2'd0, 32'h0, 1, 32'h3010, 32'd3, {32'h3020, 32'h2030, 32'h1010, 32'h30});
        add(4'b1111, 1, 0, 2'd0, 32'h0, 1, 32'h3010, 32'd3, {32'h3020, 32'h2030, 32'h1010, 32'h30});
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h30,   32'd0, {32'h3020, 32'h2030, 32'h1010, 32'h40});
        add(4'b1111, 0, 1, 2'd1, 32'h8000, 1, 32'h2030, 32'd2, {32'h3020, 32'h2040, 32'h8000, 32'h40});
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h3020, 32'd3, {32'h3030, 32'h2040, 32'h8000, 32'h40});
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h40,   32'd0, {32'h3030, 32'h2040, 32'h8000, 32'h50});
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h8000, 32'd1, {32'h3030, 32'h2040, 32'h8010, 32'h50});
        add(4'b0010, 0, 0, 2'd0, 32'h0, 1, 32'h8010, 32'd1, {32'h3030, 32'h2040, 32'h8020, 32'h50});
        add(4'b1111, 1, 1, 2'd3, 32'h5000, 1, 32'h8010, 32'd1, {32'h5000, 32'h2040, 32'h8020, 32'h50});
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h2040, 32'd2, {32'h5000, 32'h2050, 32'h8020, 32'h50});
        add(4'b1111, 0, 0, 2'd0, 32'h0, 1, 32'h5000, 32'd3, {32'h5010, 32'h2050, 32'h8020, 32'h50});
        add(4'b1111, 0, 1, 2'd0, 32'hFFFF_FFF0, 1, 32'h8020, 32'd1, {32'h5010, 32'h2050, 32'h8030, 32'hFFFF_FFF0});
        add(4'b0001, 0, 0, 2'd0, 32'h0, 1, 32'hFFFF_FFF0, 32'd0, {32'h5010, 32'h2050, 32'h8030, 32'h0});
        add(4'b0001, 0, 0, 2'd0, 32'h0, 1, 32'h0,    32'd0, {32'h5010, 32'h2050, 32'h8030, 32'h10});
        add(4'b0001, 0, 1, 2'd0, 32'h100, 0, 32'h0,  32'd0, {32'h5010, 32'h2050, 32'h8030, 32'h100});
        add(4'b0001, 0, 0, 2'd0, 32'h0, 1, 32'h100,  32'd0, {32'h5010, 32'h2050, 32'h8030, 32'h110});

        rst_n = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1 chk_all("reset", 1'b0, 32'h0, 32'd0, RST_TPC);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].ready, tbl[i].stall, tbl[i].rv, tbl[i].rt, tbl[i].rpc);
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eth, tbl[i].etpc);
        end

        // Asynchronous reset between edges: state must clear without a clock.
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 1'b0, 32'h0, 32'd0, RST_TPC);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0110, 1'b0, 1'b0, 2'd0, 32'h0);
        @(posedge clk);
        #1 chk_all("post_rst0", 1'b1, 32'h1000, 32'd1, {32'h3000, 32'h2000, 32'h1010, 32'h0});
        @(negedge clk);
        drive(4'b1111, 1'b0, 1'b0, 2'd0, 32'h0);
        @(posedge clk);
        #1 chk_all("post_rst1", 1'b1, 32'h2000, 32'd2, {32'h3000, 32'h2010, 32'h1010, 32'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thread_fetch_sched.md
# thread_fetch_sched

Round-robin fetch scheduler for the 4-thread SMT front end. It holds one program counter per hardware thread and each cycle selects one eligible thread to fetch a 4-instruction bundle. It drives the fetch address to instruction memory and a registered thread ID that tags the returned bundle for the thread demultiplexer downstream. Branch/exception redirects from the back end overwrite the PC of the affected thread.

## Interface
- ADDRESS_WIDTH, 32: PC width and width of o_thread (matches the demux thread-select input).
- FETCH_WIDTH, 4: instructions per fetch bundle; PC step = 4*FETCH_WIDTH bytes.
- RESET_PC_BASE, 32'h0000_0000: reset PC of thread 0.
- THREAD_PC_STRIDE, 32'h0000_1000: reset PC offset between consecutive threads.

- i_Clk  in  1  clock, rising edge.
- i_Reset_n  in  1  reset, asynchronous, active-low.
- i_Stall  in  1  global front-end stall; freezes scheduling.
- i_Thread_Ready  in  4  bit n=1: thread n may fetch (downstream buffer has room, thread not blocked).
- i_Redirect_Valid  in  1  redirect request this cycle.
- i_Redirect_Thread  in  2  thread being redirected.
- i_Redirect_PC  in  ADDRESS_WIDTH  new PC for that thread.
- o_Fetch_Valid  out  1  o_Fetch_PC/o_thread describe a fetch issued this cycle.
- o_Fetch_PC  out  ADDRESS_WIDTH  fetch address of the selected thread.
- o_thread  out  ADDRESS_WIDTH  selected thread ID 0..3, zero-extended.
- o_Thread_PC  out  4*ADDRESS_WIDTH  all current PCs, thread 3 in MSBs (debug/commit compare).

## Operation
- State: pc[0..3], last-grant pointer last[1:0].
- Reset: pc[n] = RESET_PC_BASE + n*THREAD_PC_STRIDE; last = 3; o_Fetch_Valid = 0; o_Fetch_PC = 0; o_thread = 0.
- Eligible set E = i_Thread_Ready with bit i_Redirect_Thread cleared when i_Redirect_Valid=1.
- Selection (i_Stall=0): search E starting at (last+1) mod 4, wrapping; first set bit n is granted.
  - Grant: o_Fetch_Valid<=1, o_Fetch_PC<=pc[n], o_thread<=n, pc[n]<=pc[n]+4*FETCH_WIDTH (mod 2^ADDRESS_WIDTH), last<=n.
  - E empty: o_Fetch_Valid<=0; o_Fetch_PC, o_thread, last, all PCs hold.
- i_Stall=1: o_Fetch_Valid, o_Fetch_PC, o_thread, last, PC increments all frozen (outputs hold previous values, including Valid).
- Redirect: pc[i_Redirect_Thread]<=i_Redirect_PC whenever i_Redirect_Valid=1, regardless of i_Stall; redirected thread is never granted in the same cycle (no increment applied to it). Value used unmodified (no alignment masking).
- Exactly one PC updated by grant, one by redirect; they never target the same thread.

## Timing
- All outputs registered; grant decision at edge k from inputs sampled at edge k, visible after edge k.
- Ready-to-fetch latency 1 cycle; redirected thread earliest re-fetch: cycle after redirect, issuing i_Redirect_PC.
- o_Thread_PC reflects PC registers directly (updated same edge as grant/redirect).
- Async reset mid-operation: all state to reset values immediately, no clock needed; first grant after release goes to lowest-index ready thread starting from 0.
- Fairness: with all 4 ready and no stall, grants rotate 0,1,2,3,0,... with no thread waiting more than 3 cycles.

## Test plan
- Reset release, i_Thread_Ready=4'b1111, no stall -> grants 0,1,2,3,0; PCs 0x0,0x1000,0x2000,0x3000 then 0x10; o_Fetch_Valid=1 every cycle.
- i_Thread_Ready=4'b0101 -> grants alternate 0,2,0,2; PCs of threads 1,3 unchanged; i_Thread_Ready=0 -> o_Fetch_Valid=0, outputs otherwise hold.
- i_Stall=1 for 3 cycles mid-sequence -> outputs/PCs frozen; after release, rotation resumes at the next thread in order with no skip.
- Redirect thread 1 to 0x0000_8000 in the cycle thread 1 would be granted -> thread 2 granted instead; next thread-1 fetch issues 0x8000, then 0x8010.
- Redirect during i_Stall=1 -> PC updated (visible on o_Thread_PC) while fetch outputs stay frozen.
- Redirect thread 0 to 0xFFFF_FFF0, grant -> next thread-0 PC wraps to 0x0000_0000; assert i_Reset_n low mid-run -> outputs 0, PCs back to reset values asynchronously.
